// File: rtl/display_arbiter_timed.sv
// display_arbiter_timed: picks one of N_SRC BCD sources for an N_DIGITS
// seven-segment display. Source 0 is shown by default. A request pulse on a
// higher source shows that source for a timed hold. Also handles priority,
// blinking, leading-zero blanking and a dash for invalid digits.
module display_arbiter_timed #(
  parameter int N_DIGITS    = 3,
  parameter int N_SRC       = 3,
  parameter int PRESCALE    = 50000,
  parameter int HOLD_TICKS  = 2000,
  parameter int BLINK_TICKS = 250,
  localparam int SRC_W      = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_SRC*N_DIGITS*4-1:0]   src_bcd,
  input  logic [N_SRC-1:0]              src_req,
  input  logic [N_SRC-1:0]              src_blink,
  input  logic [N_SRC-1:0]              src_blank_lz,
  output logic [N_DIGITS*7-1:0]         digits,
  output logic [SRC_W-1:0]              active_src,
  output logic                          hold_active
);

  localparam int PRE_W   = $clog2(PRESCALE);
  localparam int HOLD_W  = $clog2(HOLD_TICKS + 1);
  localparam int BLINK_W = $clog2(BLINK_TICKS + 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t               state, next_state;
  logic [PRE_W-1:0]     pre_cnt;
  logic                 tick;
  logic [HOLD_W-1:0]    hold_cnt, next_hold;
  logic [BLINK_W-1:0]   blink_cnt, next_blink_cnt;
  logic                 blink_phase, next_phase;
  logic                 win_valid;
  logic [SRC_W-1:0]     win_idx;
  logic [SRC_W-1:0]     next_src;
  logic [N_DIGITS*7-1:0] next_digits;
  logic [3:0]           nib;
  logic                 zero_run;

  // Segment pattern {g,f,e,d,c,b,a}, active low; values above 9 show a dash.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b0111111;
    endcase
  endfunction

  assign tick = (pre_cnt == PRE_W'(PRESCALE - 1));

  // Free-running prescaler that produces one tick every PRESCALE cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else pre_cnt <= pre_cnt + PRE_W'(1);
  end

  // Winner is the highest-indexed requesting override source (source 0 excluded).
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int s = 1; s < N_SRC; s++) begin
      if (src_req[s]) begin
        win_valid = 1'b1;
        win_idx   = SRC_W'(s);
      end
    end
  end

  // Next FSM state: accepted requests beat cancels and ticks; ticks count the hold down.
  always_comb begin
    next_state = state;
    next_src   = active_src;
    next_hold  = hold_cnt;
    case (state)
      IDLE: begin
        if (win_valid) begin
          next_state = HOLD;
          next_src   = win_idx;
          next_hold  = HOLD_W'(HOLD_TICKS);
        end
      end
      HOLD: begin
        if (win_valid && (win_idx >= active_src)) begin
          next_src  = win_idx;
          next_hold = HOLD_W'(HOLD_TICKS);
        end else if (src_req[0] && !win_valid) begin
          next_state = IDLE;
          next_src   = '0;
          next_hold  = '0;
        end else if (tick) begin
          if (hold_cnt <= HOLD_W'(1)) begin
            next_state = IDLE;
            next_src   = '0;
            next_hold  = '0;
          end else begin
            next_hold = hold_cnt - HOLD_W'(1);
          end
        end
      end
      default: begin
        next_state = IDLE;
        next_src   = '0;
        next_hold  = '0;
      end
    endcase
  end

  // Blink timing runs freely on ticks, independent of which source is shown.
  always_comb begin
    next_blink_cnt = blink_cnt;
    next_phase     = blink_phase;
    if (tick) begin
      if (blink_cnt == BLINK_W'(BLINK_TICKS - 1)) begin
        next_blink_cnt = '0;
        next_phase     = ~blink_phase;
      end else begin
        next_blink_cnt = blink_cnt + BLINK_W'(1);
      end
    end
  end

  // Render the source being selected this edge, scanning from the top digit down for blanking.
  always_comb begin
    next_digits = '1;
    nib         = '0;
    zero_run    = 1'b1;
    for (int d = N_DIGITS - 1; d >= 0; d--) begin
      nib = src_bcd[(int'(next_src) * N_DIGITS + d) * 4 +: 4];
      if (nib != 4'd0) zero_run = 1'b0;
      if ((d != 0) && zero_run && src_blank_lz[next_src])
        next_digits[d*7 +: 7] = 7'b1111111;
      else
        next_digits[d*7 +: 7] = seg7(nib);
    end
    if (src_blink[next_src] && next_phase) next_digits = '1;
  end

  // FSM and registered outputs share one edge so digits track the new source immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      active_src  <= '0;
      hold_active <= 1'b0;
      hold_cnt    <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      digits      <= '1;
    end else begin
      state       <= next_state;
      active_src  <= next_src;
      hold_active <= (next_state == HOLD);
      hold_cnt    <= next_hold;
      blink_cnt   <= next_blink_cnt;
      blink_phase <= next_phase;
      digits      <= next_digits;
    end
  end

endmodule

// File: tb/tb_display_arbiter_timed.sv
// tb_display_arbiter_timed: directed stimulus with a scoreboard queue of
// expected display states, popped and compared by a separate monitor.
module tb_display_arbiter_timed;

  localparam int ND = 3;
  localparam int NS = 3;

  localparam logic [6:0] S0   = 7'b1000000;
  localparam logic [6:0] S1   = 7'b1111001;
  localparam logic [6:0] S2   = 7'b0100100;
  localparam logic [6:0] S3   = 7'b0110000;
  localparam logic [6:0] S4   = 7'b0011001;
  localparam logic [6:0] S5   = 7'b0010010;
  localparam logic [6:0] S7   = 7'b1111000;
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] BLK  = 7'b1111111;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NS*ND*4-1:0]   src_bcd;
  logic [NS-1:0]        src_req;
  logic [NS-1:0]        src_blink;
  logic [NS-1:0]        src_blank_lz;
  logic [ND*7-1:0]      digits;
  logic [1:0]           active_src;
  logic                 hold_active;

  typedef struct packed {
    logic [20:0] dig;
    logic [1:0]  src;
    logic        hold;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;
  int    edge_cnt;

  display_arbiter_timed #(
    .N_DIGITS(3), .N_SRC(3), .PRESCALE(4), .HOLD_TICKS(3), .BLINK_TICKS(2)
  ) dut (
    .clk(clk), .reset(reset), .src_bcd(src_bcd), .src_req(src_req),
    .src_blink(src_blink), .src_blank_lz(src_blank_lz),
    .digits(digits), .active_src(active_src), .hold_active(hold_active)
  );

  always #5 clk = ~clk;

  // Reference count of clock edges since reset release, used to predict blink phase.
  always @(posedge clk or negedge reset) begin
    if (!reset) edge_cnt <= 0;
    else edge_cnt <= edge_cnt + 1;
  end

  // Monitor: compare every queued expectation against the outputs on the falling edge.
  always @(negedge clk) begin
    exp_t  e;
    string n;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if ({digits, active_src, hold_active} !== e) begin
        errors++;
        $display("[TB] FAIL %s: got digits=%b src=%0d hold=%b, expected digits=%b src=%0d hold=%b",
                 n, digits, active_src, hold_active, e.dig, e.src, e.hold);
      end
    end
  end

  task automatic push_exp(input string name, input logic [20:0] dig,
                          input logic [1:0] src, input logic hold);
    exp_t e;
    e.dig  = dig;
    e.src  = src;
    e.hold = hold;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  task automatic check_range(input string name, input int v, input int lo, input int hi);
    checks++;
    if (v < lo || v > hi) begin
      errors++;
      $display("[TB] FAIL %s: got %0d cycles, expected %0d..%0d", name, v, lo, hi);
    end
  endtask

  task automatic set_bcd(input int s, input logic [3:0] d2, input logic [3:0] d1,
                         input logic [3:0] d0);
    src_bcd[(s*ND+0)*4 +: 4] = d0;
    src_bcd[(s*ND+1)*4 +: 4] = d1;
    src_bcd[(s*ND+2)*4 +: 4] = d2;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [NS-1:0] bits);
    @(negedge clk);
    src_req = bits;
    @(posedge clk);
    #1;
    src_req = '0;
  endtask

  task automatic measure_hold(input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (hold_active === 1'b1 && n < 20);
    check_range(name, n, 9, 12);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w;
    reset        = 1'b0;
    src_bcd      = '0;
    src_req      = '0;
    src_blink    = '0;
    src_blank_lz = '0;
    set_bcd(0, 4'd1, 4'd2, 4'd5);

    repeat (3) begin
      @(posedge clk);
      #1;
      push_exp("reset_blank", {BLK, BLK, BLK}, 2'd0, 1'b0);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    push_exp("default_src0", {S1, S2, S5}, 2'd0, 1'b0);

    set_bcd(1, 4'd0, 4'd4, 4'd2);
    src_blank_lz[1] = 1'b1;
    pulse(3'b010);
    push_exp("override_src1", {BLK, S4, S2}, 2'd1, 1'b1);
    measure_hold("override_len");
    push_exp("override_return", {S1, S2, S5}, 2'd0, 1'b0);

    set_bcd(2, 4'd0, 4'd0, 4'd7);
    pulse(3'b100);
    push_exp("prio_src2", {S0, S0, S7}, 2'd2, 1'b1);
    wait_cycles(1);
    pulse(3'b010);
    push_exp("prio_low_ignored", {S0, S0, S7}, 2'd2, 1'b1);
    wait_cycles(3);
    pulse(3'b100);
    push_exp("prio_restart", {S0, S0, S7}, 2'd2, 1'b1);
    measure_hold("restart_len");
    push_exp("restart_return", {S1, S2, S5}, 2'd0, 1'b0);

    pulse(3'b010);
    push_exp("cancel_setup", {BLK, S4, S2}, 2'd1, 1'b1);
    pulse(3'b011);
    push_exp("simul_req0_req1", {BLK, S4, S2}, 2'd1, 1'b1);
    pulse(3'b001);
    push_exp("cancel", {S1, S2, S5}, 2'd0, 1'b0);
    pulse(3'b001);
    push_exp("req0_in_idle", {S1, S2, S5}, 2'd0, 1'b0);

    @(negedge clk);
    set_bcd(0, 4'd12, 4'd3, 4'd0);
    src_blink[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (((edge_cnt / 8) % 2) == 1)
        push_exp("blink_off", {BLK, BLK, BLK}, 2'd0, 1'b0);
      else
        push_exp("blink_on", {DASH, S3, S0}, 2'd0, 1'b0);
    end

    @(negedge clk);
    src_blink[0] = 1'b0;
    pulse(3'b010);
    push_exp("hold_before_reset", {BLK, S4, S2}, 2'd1, 1'b1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    push_exp("async_reset", {BLK, BLK, BLK}, 2'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    push_exp("after_reset", {DASH, S3, S0}, 2'd0, 1'b0);

    w = 0;
    while (exp_q.size() > 0 && w < 10) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
